// File: rtl/serial_addsub_unit_if.sv
// Operand/result handshake bundle for serial_addsub_unit.
// ovf exists only when ADDSUB_OVF_EN is defined.
interface serial_addsub_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef ADDSUB_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, mode, a, b, cin, out_ready,
    input  in_ready, out_valid, result, cout, ovf
  );

  modport slave (
    input  in_valid, mode, a, b, cin, out_ready,
    output in_ready, out_valid, result, cout, ovf
  );
`else
  modport master (
    output in_valid, mode, a, b, cin, out_ready,
    input  in_ready, out_valid, result, cout
  );

  modport slave (
    input  in_valid, mode, a, b, cin, out_ready,
    output in_ready, out_valid, result, cout
  );
`endif
endinterface

// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract, DIGIT bits per cycle, LSB first.
// Optional signed overflow flag: define ADDSUB_OVF_EN.
module serial_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_addsub_unit_if.slave io
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             mode_q;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] xd;
  logic [DIGIT-1:0] yd;
  logic [DIGIT-1:0] sd;
  logic             c_nx;
  logic             c_msb;
  logic             last;
  logic             accept;
  logic             retire;

  assign last   = (cnt == CW'(NDIG - 1));
  assign accept = (state == IDLE) && io.in_valid;
  assign retire = (state == DONE) && io.out_ready;

  assign xd = a_q[int'(cnt)*DIGIT +: DIGIT];
  assign yd = b_q[int'(cnt)*DIGIT +: DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // c_msb keeps the carry/borrow entering the top cell of the digit
  always_comb begin
    c_nx  = c_q;
    c_msb = c_q;
    sd    = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        c_msb = c_nx;
      end
      sd[i] = xd[i] ^ yd[i] ^ c_nx;
      if (mode_q) begin
        c_nx = (~xd[i] & yd[i])
             | (~(xd[i] ^ yd[i]) & c_nx);
      end else begin
        c_nx = (xd[i] & yd[i])
             | (yd[i] & c_nx)
             | (xd[i] & c_nx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      mode_q <= 1'b0;
      c_q    <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_q    <= io.a;
      b_q    <= io.b;
      res_q  <= '0;
      mode_q <= io.mode;
      c_q    <= io.cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      res_q[int'(cnt)*DIGIT +: DIGIT] <= sd;
      c_q <= c_nx;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  assign io.result = res_q;
  assign io.cout   = c_q;

`ifdef ADDSUB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept || retire) begin
      ovf_q <= 1'b0;
    end else if ((state == RUN) && last) begin
      ovf_q <= c_msb ^ c_nx;
    end
  end

  assign io.ovf = ovf_q & (state == DONE);
`else
  logic unused_msb;
  assign unused_msb = c_msb;
`endif

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Randomized self-checking bench for serial_addsub_unit.
// Runs DIGIT=4, DIGIT=1 and DIGIT=16 instances, one selected at a time.
module tb_serial_addsub_unit;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        in_valid;
  logic        mode;
  logic        cin;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_addsub_unit_if #(.WIDTH(16)) if4 ();
  serial_addsub_unit_if #(.WIDTH(16)) if1 ();
  serial_addsub_unit_if #(.WIDTH(16)) if16 ();

  assign if4.in_valid   = in_valid && (sel == 0);
  assign if1.in_valid   = in_valid && (sel == 1);
  assign if16.in_valid  = in_valid && (sel == 2);
  assign if4.out_ready  = out_ready;
  assign if1.out_ready  = out_ready;
  assign if16.out_ready = out_ready;
  assign if4.mode = mode;
  assign if1.mode = mode;
  assign if16.mode = mode;
  assign if4.a = a;
  assign if1.a = a;
  assign if16.a = a;
  assign if4.b = b;
  assign if1.b = b;
  assign if16.b = b;
  assign if4.cin = cin;
  assign if1.cin = cin;
  assign if16.cin = cin;

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .io(if4)
  );
  serial_addsub_unit #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .io(if1)
  );
  serial_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .io(if16)
  );

  always_comb begin
    in_ready  = if4.in_ready;
    out_valid = if4.out_valid;
    result    = if4.result;
    cout      = if4.cout;
    ovf       = 1'b0;
`ifdef ADDSUB_OVF_EN
    ovf       = if4.ovf;
`endif
    if (sel == 1) begin
      in_ready  = if1.in_ready;
      out_valid = if1.out_valid;
      result    = if1.result;
      cout      = if1.cout;
`ifdef ADDSUB_OVF_EN
      ovf       = if1.ovf;
`endif
    end else if (sel == 2) begin
      in_ready  = if16.in_ready;
      out_valid = if16.out_valid;
      result    = if16.result;
      cout      = if16.cout;
`ifdef ADDSUB_OVF_EN
      ovf       = if16.ovf;
`endif
    end
  end

  // {ovf, cout, result} from plain integer arithmetic
  function automatic logic [17:0] model(
    input logic m, input logic [15:0] x,
    input logic [15:0] y, input logic c
  );
    int ux, uy, sx, sy, ci, ur, sr;
    logic co, ov;
    logic [15:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ci = c ? 1 : 0;
    if (m) begin
      ur = ux - uy - ci;
      sr = sx - sy - ci;
      co = (ux < uy + ci);
    end else begin
      ur = ux + uy + ci;
      sr = sx + sy + ci;
      co = (ur > 65535);
    end
    r  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, r};
  endfunction

  task automatic start_txn(
    input logic m, input logic [15:0] x,
    input logic [15:0] y, input logic c,
    output bit to
  );
    int n = 0;
    to = 1'b0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      to = 1'b1;
      return;
    end
    mode = m; a = x; b = y; cin = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    mode = 1'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit to);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    to = !out_valid;
  endtask

  task automatic finish_txn();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
          result !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
        $display("FAIL reset sel=%0d: rdy=%b vld=%b res=%h co=%b ov=%b, want 1 0 0000 0 0",
                 s, in_ready, out_valid, result, cout, ovf);
      end else passed++;
    end
    sel = 0;
  endtask

  task automatic test_add_wrap();
    bit to;
    int lat;
    start_txn(1'b0, 16'hFFFF, 16'h0001, 1'b0, to);
    wait_done(lat, to);
    checks++;
    if (to || lat !== 4) begin
      $display("FAIL add_latency: got %0d (timeout=%0d), want 4", lat, to);
    end else passed++;
    checks++;
    if (result !== 16'h0000 || cout !== 1'b1) begin
      $display("FAIL add_wrap: got %h/%b, want 0000/1", result, cout);
    end else passed++;
    finish_txn();
  endtask

  task automatic test_subtract();
    bit to;
    int lat;
    start_txn(1'b1, 16'h0003, 16'h0005, 1'b0, to);
    wait_done(lat, to);
    checks++;
    if (to || result !== 16'hFFFE || cout !== 1'b1) begin
      $display("FAIL sub_neg: got %h/%b to=%0d, want fffe/1", result, cout, to);
    end else passed++;
    finish_txn();
    start_txn(1'b1, 16'h1000, 16'h0FFF, 1'b1, to);
    wait_done(lat, to);
    checks++;
    if (to || result !== 16'h0000 || cout !== 1'b0) begin
      $display("FAIL sub_borrow_in: got %h/%b to=%0d, want 0000/0", result, cout, to);
    end else passed++;
    finish_txn();
  endtask

  task automatic test_backpressure();
    bit to;
    int lat;
    int bad = 0;
    start_txn(1'b0, 16'h1111, 16'h2222, 1'b0, to);
    wait_done(lat, to);
    checks++;
    if (to || result !== 16'h3333) begin
      $display("FAIL bp_first: got %h to=%0d, want 3333", result, to);
    end else passed++;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk); #1;
      if (result !== 16'h3333 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL bp_hold: %0d bad cycles, last res=%h rdy=%b vld=%b, want 3333 0 1",
               bad, result, in_ready, out_valid);
    end else passed++;
    in_valid = 1'b0;
    finish_txn();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end else passed++;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL bp_no_ghost: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end else passed++;
  endtask

  task automatic test_reset_mid_run();
    bit to;
    int lat;
    start_txn(1'b0, 16'hAAAA, 16'h5555, 1'b1, to);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0 || in_ready !== 1'b1) begin
      $display("FAIL mid_run_reset: vld=%b res=%h rdy=%b, want 0 0000 1",
               out_valid, result, in_ready);
    end else passed++;
    start_txn(1'b0, 16'h1234, 16'h4321, 1'b0, to);
    wait_done(lat, to);
    checks++;
    if (to || result !== 16'h5555 || cout !== 1'b0) begin
      $display("FAIL after_reset: got %h/%b to=%0d, want 5555/0", result, cout, to);
    end else passed++;
    finish_txn();
  endtask

  task automatic test_back_to_back();
    bit to;
    int lat;
    int nd;
    int stall;
    logic m, c;
    logic [15:0] x, y;
    logic [17:0] exp;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      nd = (s == 0) ? 4 : ((s == 1) ? 16 : 1);
      #1;
      for (int t = 0; t < 50; t++) begin
        m = 1'($urandom);
        c = 1'($urandom);
        x = 16'($urandom);
        y = 16'($urandom);
        if ($urandom_range(0, 7) == 0) x = 16'hFFFF;
        if ($urandom_range(0, 7) == 0) y = 16'h8000;
        stall = $urandom_range(0, 3);
        exp = model(m, x, y, c);
        start_txn(m, x, y, c, to);
        wait_done(lat, to);
        checks++;
        if (to || lat != nd) begin
          $display("FAIL b2b_latency d=%0d #%0d: got %0d to=%0d, want %0d",
                   16 / nd, t, lat, to, nd);
        end else passed++;
        checks++;
        if (result !== exp[15:0] || cout !== exp[16]) begin
          $display("FAIL b2b_value d=%0d #%0d m=%b %h,%h,%b: got %h/%b, want %h/%b",
                   16 / nd, t, m, x, y, c, result, cout, exp[15:0], exp[16]);
        end else passed++;
`ifdef ADDSUB_OVF_EN
        checks++;
        if (ovf !== exp[17]) begin
          $display("FAIL b2b_ovf d=%0d #%0d: got %b, want %b", 16 / nd, t, ovf, exp[17]);
        end else passed++;
`endif
        repeat (stall) begin
          @(posedge clk); #1;
        end
        finish_txn();
      end
    end
    sel = 0;
    #1;
  endtask

`ifdef ADDSUB_OVF_EN
  task automatic test_ovf();
    bit to;
    int lat;
    start_txn(1'b0, 16'h7FFF, 16'h0001, 1'b0, to);
    wait_done(lat, to);
    checks++;
    if (to || ovf !== 1'b1 || cout !== 1'b0 || result !== 16'h8000) begin
      $display("FAIL ovf_add: got ov=%b co=%b res=%h, want 1 0 8000", ovf, cout, result);
    end else passed++;
    finish_txn();
    checks++;
    if (ovf !== 1'b0) begin
      $display("FAIL ovf_idle: got %b, want 0", ovf);
    end else passed++;
    start_txn(1'b1, 16'h8000, 16'h0001, 1'b0, to);
    wait_done(lat, to);
    checks++;
    if (to || ovf !== 1'b1 || result !== 16'h7FFF) begin
      $display("FAIL ovf_sub: got ov=%b res=%h, want 1 7fff", ovf, result);
    end else passed++;
    finish_txn();
    start_txn(1'b1, 16'h0005, 16'h0003, 1'b0, to);
    wait_done(lat, to);
    checks++;
    if (to || ovf !== 1'b0 || result !== 16'h0002) begin
      $display("FAIL ovf_none: got ov=%b res=%h, want 0 0002", ovf, result);
    end else passed++;
    finish_txn();
  endtask
`endif

  initial begin
    rst = 1'b1;
    sel = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = 1'b0;
    cin = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_add_wrap();
    test_subtract();
    test_backpressure();
    test_reset_mid_run();
`ifdef ADDSUB_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub_unit.md
# serial_addsub_unit

Parametrised, digit-serial adder/subtractor that extends the team's single-bit full adder and full subtractor cells to WIDTH-bit operands. It processes DIGIT bits per clock through a registered carry/borrow chain, and selects add or subtract per transaction. Operands enter through a valid/ready handshake and results leave through one. It sits between operand-issue logic and any consumer that tolerates multi-cycle latency in exchange for a narrow DIGIT-bit datapath.

## Interface
- WIDTH, 16, operand/result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per RUN cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- mode  in  1  0 = add (a + b + cin), 1 = subtract (a − b − cin, cin is borrow-in).
- a  in  WIDTH  minuend / addend A, unsigned.
- b  in  WIDTH  subtrahend / addend B, unsigned.
- cin  in  1  carry-in (add) or borrow-in (subtract).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  carry-out (add) or borrow-out (subtract).
- ovf  out  1  signed overflow flag; present only with ADDSUB_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid is high on an edge, the unit captures a, b, mode and cin, clears the digit counter, and moves to RUN.
- RUN: on each edge the unit computes digit k (LSB first) with DIGIT chained full-add or full-subtract cells. The chain-in is the registered carry/borrow. The unit writes result[k*DIGIT +: DIGIT], updates the carry/borrow register and increments k. After digit NDIG−1 it moves to DONE.
- Add cell equations: s = x^y^c; c' = xy | yc | xc.
- Subtract cell equations: d = x^y^c; c' = (~x&y) | (~(x^y)&c).
- DONE: out_valid=1; result and cout are stable. The unit returns to IDLE on the edge where out_ready=1.
- Input captured at acceptance is authoritative; changes to a, b, mode or cin after acceptance are ignored.
- in_valid while not IDLE is ignored; in_ready=0, so no transaction is lost or accepted.
- Subtract borrow semantics: cout=1 exactly when unsigned a < b + cin.
- result in DONE equals (a ± b ± cin) mod 2^WIDTH, bit-exact to a WIDTH-bit ripple of the single-bit cells.

## Timing
- Reset (rst=1 on an edge) forces: state=IDLE, in_ready=1 after reset, out_valid=0, result=0, cout=0, ovf=0, digit counter=0.
- Reset has priority over every other event, including mid-RUN and DONE. An in-flight transaction is discarded with no output.
- Latency: the acceptance edge is E0. RUN edges are E1..E_NDIG. out_valid is high starting the cycle after E_NDIG, so latency is NDIG cycles.
- DIGIT=WIDTH (NDIG=1): single RUN cycle.
- Throughput: one transaction per NDIG+2 cycles at best (accept, NDIG RUN, DONE handshake edge). in_ready returns the cycle after the output handshake; there is no same-cycle bypass.
- Backpressure: out_ready low holds DONE indefinitely, with outputs frozen.
- in_ready and out_valid are never high together.

## Configuration
- ADDSUB_OVF_EN defined:
  - The ovf port exists. In DONE, ovf is the XOR of the carries into and out of the MSB cell (two's-complement overflow for both modes).
  - ovf is registered with result, is 0 outside DONE, and is 0 after reset.
- ADDSUB_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=16 and DIGIT=4.
- Add 0xFFFF + 0x0001, cin=0, mode=0 → result 0x0000, cout=1, out_valid exactly 4 cycles after the acceptance edge.
- Subtract 0x0003 − 0x0005, cin=0, mode=1 → result 0xFFFE, cout=1. Then 0x1000 − 0x0FFF with cin=1 → result 0x0000, cout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid, a and b → result is stable, in_ready=0 throughout, and no second transaction is accepted. Raise out_ready → IDLE next cycle.
- Assert rst during RUN digit 2 → next cycle out_valid=0, result=0, in_ready=1. A following transaction 0x1234 + 0x4321 → result 0x5555, cout=0.
- Back-to-back: 50 random add/subtract transactions with random cin and random out_ready stalls → every result and cout matches the reference arithmetic. Repeat at DIGIT=1 and DIGIT=16.
- With ADDSUB_OVF_EN:
  - 0x7FFF + 0x0001 → ovf=1, cout=0.
  - 0x8000 − 0x0001 → result 0x7FFF, ovf=1.
  - 0x0005 − 0x0003 → ovf=0.
